// File: rtl/alu_control_unit.sv
// Multi-cycle control FSM sitting in front of a purely combinational ALU: accepts one
// instruction over valid/ready and sequences register reads, ALU selects, memory and writeback.
module alu_control_unit #(
  parameter int INSTR_WIDTH   = 16,
  parameter int REG_SEL_WIDTH = 4,
  parameter int MEM_TIMEOUT   = 8,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  // Handshake: Instr_In is taken on a rising edge where Instr_Valid && Instr_Ready; the
  // source holds Instr_In stable while Instr_Valid is high and Instr_Ready is low.
  input  logic                     Instr_Valid,
  input  logic [INSTR_WIDTH-1:0]   Instr_In,
  output logic                     Instr_Ready,
  input  logic                     Resume,
  input  logic                     Mem_Ack,
  output logic [REG_SEL_WIDTH-1:0] Reg1_Sel,
  output logic [REG_SEL_WIDTH-1:0] Reg2_Sel,
  output logic [REG_SEL_WIDTH-1:0] Reg_Wr_Sel,
  output logic                     Reg_Wr_En,
  output logic                     Wb_Src_Mem,
  output logic                     Alu_Add,
  output logic                     Alu_Sub,
  output logic                     Alu_Mul,
  output logic                     Alu_Pass,
  output logic                     Mem_Rd,
  output logic                     Mem_Wr,
  output logic                     Pc_Inc,
  output logic                     Illegal,
  output logic                     Mem_Err,
  output logic                     Halted,
  output logic [CNT_WIDTH-1:0]     Retired_Count,
  output logic [2:0]               Dbg_State
);

  localparam int            TW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_LOAD  = 4'd4;
  localparam logic [3:0] OP_STORE = 4'd5;
  localparam logic [3:0] OP_HALT  = 4'd6;

  // FETCH encodes as 0 so the debug state reads 0 while in reset, like every other output.
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_MEM       = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t                 state;
  logic [INSTR_WIDTH-1:0] ir;
  logic [TW-1:0]          tmo_cnt;
  logic [CNT_WIDTH-1:0]   retired;
  logic                   err_flag;
  logic [3:0]             opcode;

  assign opcode = ir[INSTR_WIDTH-1 -: 4];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_FETCH;
      ir       <= '0;
      tmo_cnt  <= '0;
      retired  <= '0;
      err_flag <= 1'b0;
    end else begin
      // err_flag marks only the single FETCH cycle that follows a memory timeout.
      err_flag <= 1'b0;
      case (state)
        S_FETCH: begin
          if (Instr_Valid) begin
            ir    <= Instr_In;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_NOP: begin
              retired <= retired + CNT_WIDTH'(1);
              state   <= S_FETCH;
            end
            OP_HALT: begin
              retired <= retired + CNT_WIDTH'(1);
              state   <= S_HALT;
            end
            OP_ADD, OP_SUB, OP_MUL: state <= S_EXECUTE;
            OP_LOAD, OP_STORE: begin
              tmo_cnt <= '0;
              state   <= S_MEM;
            end
            default: state <= S_FETCH;
          endcase
        end
        S_EXECUTE: state <= S_WRITEBACK;
        S_WRITEBACK: begin
          retired <= retired + CNT_WIDTH'(1);
          state   <= S_FETCH;
        end
        S_MEM: begin
          if (Mem_Ack) begin
            if (opcode == OP_LOAD) begin
              state <= S_WRITEBACK;
            end else begin
              retired <= retired + CNT_WIDTH'(1);
              state   <= S_FETCH;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            err_flag <= 1'b1;
            state    <= S_FETCH;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_HALT: begin
          if (Resume) state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  logic in_alu_phase;
  assign in_alu_phase = (state == S_EXECUTE) || (state == S_WRITEBACK);

  // Ready is gated by Rst_n so it only rises once reset is released.
  assign Instr_Ready   = (state == S_FETCH) && Rst_n;
  assign Reg1_Sel      = ir[REG_SEL_WIDTH +: REG_SEL_WIDTH];
  assign Reg2_Sel      = ir[0 +: REG_SEL_WIDTH];
  assign Reg_Wr_Sel    = ir[2*REG_SEL_WIDTH +: REG_SEL_WIDTH];
  assign Reg_Wr_En     = (state == S_WRITEBACK);
  assign Wb_Src_Mem    = (state == S_WRITEBACK) && (opcode == OP_LOAD);
  assign Alu_Add       = in_alu_phase && (opcode == OP_ADD);
  assign Alu_Sub       = in_alu_phase && (opcode == OP_SUB);
  assign Alu_Mul       = in_alu_phase && (opcode == OP_MUL);
  assign Alu_Pass      = (state == S_MEM) && (opcode == OP_STORE);
  assign Mem_Rd        = (state == S_MEM) && (opcode == OP_LOAD);
  assign Mem_Wr        = (state == S_MEM) && (opcode == OP_STORE);
  assign Pc_Inc        = (state == S_DECODE);
  assign Illegal       = (state == S_DECODE) && (opcode > OP_HALT);
  assign Mem_Err       = err_flag && (state == S_FETCH);
  assign Halted        = (state == S_HALT);
  assign Retired_Count = retired;
  assign Dbg_State     = state;

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: a per-instruction cycle-trace model drives inputs and predicts
// every output each cycle; named pins check directed scenarios and the model's own figures.
module tb_alu_control_unit;

  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 4;  // narrow counter so random traffic exercises the wrap
  localparam int EW          = 13 + 12 + CNT_W;
  localparam int SW          = 19;

  // Flag masks within the 13-bit flag field; also the tally indices (bit numbers).
  localparam logic [12:0] RDY = 13'h1000, PC = 13'h0800, ILL = 13'h0400, ADD = 13'h0200;
  localparam logic [12:0] SUB = 13'h0100, MUL = 13'h0080, PASS = 13'h0040, WR = 13'h0020;
  localparam logic [12:0] WBM = 13'h0010, MRD = 13'h0008, MWR = 13'h0004, ERR = 13'h0002;
  localparam logic [12:0] HLT = 13'h0001;
  localparam int T_RDY = 12, T_PC = 11, T_ILL = 10, T_ADD = 9, T_MUL = 7, T_PASS = 6;
  localparam int T_WR = 5, T_MRD = 3, T_MWR = 2, T_ERR = 1, T_HLT = 0;

  logic Clk, Rst_n, Instr_Valid, Resume, Mem_Ack;
  logic [15:0] Instr_In;
  logic Instr_Ready, Reg_Wr_En, Wb_Src_Mem, Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass;
  logic Mem_Rd, Mem_Wr, Pc_Inc, Illegal, Mem_Err, Halted;
  logic [3:0] Reg1_Sel, Reg2_Sel, Reg_Wr_Sel;
  logic [CNT_W-1:0] Retired_Count;
  logic [2:0] Dbg_State;

  alu_control_unit #(
    .INSTR_WIDTH(16), .REG_SEL_WIDTH(4), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(CNT_W)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Instr_Valid(Instr_Valid), .Instr_In(Instr_In),
    .Instr_Ready(Instr_Ready), .Resume(Resume), .Mem_Ack(Mem_Ack),
    .Reg1_Sel(Reg1_Sel), .Reg2_Sel(Reg2_Sel), .Reg_Wr_Sel(Reg_Wr_Sel),
    .Reg_Wr_En(Reg_Wr_En), .Wb_Src_Mem(Wb_Src_Mem), .Alu_Add(Alu_Add), .Alu_Sub(Alu_Sub),
    .Alu_Mul(Alu_Mul), .Alu_Pass(Alu_Pass), .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr),
    .Pc_Inc(Pc_Inc), .Illegal(Illegal), .Mem_Err(Mem_Err), .Halted(Halted),
    .Retired_Count(Retired_Count), .Dbg_State(Dbg_State)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- model state and queues ----------------
  logic [15:0]      ir_m;
  logic [CNT_W-1:0] cnt_m;
  bit               err_m;
  logic [SW-1:0]    plan_stim_q[$];
  logic [EW-1:0]    plan_exp_q[$];
  logic [EW-1:0]    exp_q[$];
  string            pin_name_q[$];
  logic [63:0]      pin_act_q[$];
  logic [63:0]      pin_exp_q[$];
  int               tally[13];
  int               base[13];
  int               checks = 0;
  int               failures = 0;

  function automatic logic [EW-1:0] act_vec();
    return {Instr_Ready, Pc_Inc, Illegal, Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass, Reg_Wr_En,
            Wb_Src_Mem, Mem_Rd, Mem_Wr, Mem_Err, Halted, Reg1_Sel, Reg2_Sel, Reg_Wr_Sel,
            Retired_Count};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] rw();
    return 16'($urandom);
  endfunction

  // One cycle of the trace: inputs to drive and the outputs that must be visible.
  function automatic void add_cycle(input logic [12:0] flags, input logic valid,
                                    input logic [15:0] instr, input logic resume,
                                    input logic ack);
    logic [12:0] f;
    f = flags;
    if ((f & RDY) != 13'h0) begin
      if (err_m) f = f | ERR;
      err_m = 1'b0;
    end
    plan_exp_q.push_back({f, ir_m[7:4], ir_m[3:0], ir_m[11:8], cnt_m});
    plan_stim_q.push_back({valid, instr, resume, ack});
  endfunction

  // nwait >= MEM_TIMEOUT means memory never acknowledges.
  function automatic void plan_instr(input logic [15:0] instr, input int gap,
                                     input int nwait, input int hold);
    logic [3:0]  op;
    logic [12:0] a;
    logic [12:0] m;
    for (int g = 0; g < gap; g++) add_cycle(RDY, 1'b0, rw(), rb(), rb());
    add_cycle(RDY, 1'b1, instr, rb(), rb());
    ir_m = instr;
    op   = instr[15:12];
    add_cycle((op >= 4'd7) ? (PC | ILL) : PC, rb(), rw(), rb(), rb());
    case (op)
      4'd0: cnt_m = cnt_m + CNT_W'(1);
      4'd6: begin
        cnt_m = cnt_m + CNT_W'(1);
        for (int h = 0; h < hold; h++) add_cycle(HLT, 1'b1, rw(), 1'b0, rb());
        add_cycle(HLT, rb(), rw(), 1'b1, rb());
      end
      4'd1, 4'd2, 4'd3: begin
        a = (op == 4'd1) ? ADD : (op == 4'd2) ? SUB : MUL;
        add_cycle(a, rb(), rw(), rb(), rb());
        add_cycle(a | WR, rb(), rw(), rb(), rb());
        cnt_m = cnt_m + CNT_W'(1);
      end
      4'd4, 4'd5: begin
        m = (op == 4'd4) ? MRD : (MWR | PASS);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
          add_cycle(m, rb(), rw(), rb(), 1'(i == nwait));
          if (i == nwait) break;
        end
        if (nwait >= MEM_TIMEOUT) begin
          err_m = 1'b1;
        end else begin
          if (op == 4'd4) add_cycle(WR | WBM, rb(), rw(), rb(), rb());
          cnt_m = cnt_m + CNT_W'(1);
        end
      end
      default: ;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic play();
    logic [SW-1:0] s;
    logic [EW-1:0] v;
    while (plan_stim_q.size() != 0) begin
      @(posedge Clk);
      #1;
      s = plan_stim_q.pop_front();
      {Instr_Valid, Instr_In, Resume, Mem_Ack} = s;
      exp_q.push_back(plan_exp_q.pop_front());
      v = act_vec();
      for (int j = 0; j < 13; j++) tally[j] += int'(v[12 + CNT_W + j]);
    end
  endtask

  function automatic void pin(input string name, input logic [63:0] act, input logic [63:0] exp);
    pin_name_q.push_back(name);
    pin_act_q.push_back(act);
    pin_exp_q.push_back(exp);
  endfunction

  function automatic int delta(input int i);
    return tally[i] - base[i];
  endfunction

  function automatic void snap();
    for (int j = 0; j < 13; j++) base[j] = tally[j];
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [EW-1:0] act_v, exp_v;
  string         pn;
  logic [63:0]   pa, pe;

  always @(negedge Clk) begin
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      act_v = act_vec();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL cycle_compare t=%0t actual=%h expected=%h", $time, act_v, exp_v);
      end
    end
    while (pin_name_q.size() != 0) begin
      pn = pin_name_q.pop_front();
      pa = pin_act_q.pop_front();
      pe = pin_exp_q.pop_front();
      checks++;
      if (pa !== pe) begin
        failures++;
        $display("FAIL %s actual=%0d expected=%0d", pn, pa, pe);
      end
    end
  end

  // ---------------- stimulus ----------------
  int          wen_seen;
  int          sel;
  logic [3:0]  op;

  initial begin
    Rst_n = 1'b0; Instr_Valid = 1'b0; Instr_In = 16'h0; Resume = 1'b0; Mem_Ack = 1'b0;
    ir_m = 16'h0; cnt_m = '0; err_m = 1'b0;
    for (int j = 0; j < 13; j++) begin tally[j] = 0; base[j] = 0; end
    repeat (3) @(posedge Clk);
    #2;
    pin("reset_outputs_zero", 64'(act_vec()), 64'(0));
    pin("reset_dbg_state", 64'(Dbg_State), 64'(0));
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    pin("ready_after_release", 64'(Instr_Ready), 64'(1));

    // ADD r3 = r2 + r1
    snap();
    plan_instr(16'h1321, 0, 0, 0);
    play();
    @(negedge Clk); #1;
    pin("add_wb_wr_en", 64'(Reg_Wr_En), 64'(1));
    pin("add_wb_wr_sel", 64'(Reg_Wr_Sel), 64'(3));
    pin("add_pc_inc_cycles", 64'(delta(T_PC)), 64'(1));
    pin("add_alu_add_cycles", 64'(delta(T_ADD)), 64'(2));

    // LOAD r2, ack after 3 wait cycles
    snap();
    plan_instr(16'h4250, 0, 3, 0);
    play();
    @(negedge Clk); #1;
    pin("load_mem_rd_cycles", 64'(delta(T_MRD)), 64'(4));
    pin("load_wb_src_mem", 64'(Wb_Src_Mem), 64'(1));
    pin("load_wb_alu_none", 64'({Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass}), 64'(0));
    pin("load_wb_retired", 64'(Retired_Count), 64'(1));
    pin("load_wb_wr_sel", 64'(Reg_Wr_Sel), 64'(2));

    // STORE with no ack: times out
    snap();
    plan_instr(16'h5014, 0, MEM_TIMEOUT, 0);
    play();
    @(negedge Clk); #1;
    pin("store_mem_wr_cycles", 64'(delta(T_MWR)), 64'(8));
    pin("store_alu_pass_cycles", 64'(delta(T_PASS)), 64'(8));

    // illegal opcode, following the timeout
    snap();
    plan_instr(16'hF000, 2, 0, 0);
    play();
    @(negedge Clk); #1;
    pin("timeout_mem_err_pulses", 64'(delta(T_ERR)), 64'(1));
    pin("illegal_pulses", 64'(delta(T_ILL)), 64'(1));
    pin("illegal_no_wr_en", 64'(delta(T_WR)), 64'(0));
    pin("illegal_no_mem", 64'(delta(T_MRD) + delta(T_MWR)), 64'(0));
    pin("retired_after_timeout", 64'(Retired_Count), 64'(2));

    // HALT held 20 cycles with Instr_Valid high, then Resume
    snap();
    plan_instr(16'h6000, 0, 0, 20);
    play();
    @(negedge Clk); #1;
    pin("halt_cycles", 64'(delta(T_HLT)), 64'(21));
    pin("halt_ready_cycles", 64'(delta(T_RDY)), 64'(1));

    // boundaries: ack on the final timeout cycle, immediate ack, NOP
    snap();
    plan_instr(16'h4730, 0, MEM_TIMEOUT - 1, 0); play();
    plan_instr(16'h5098, 0, 0, 0); play();
    plan_instr(16'h0ABC, 1, 0, 0); play();
    @(negedge Clk); #1;
    pin("late_ack_no_mem_err", 64'(delta(T_ERR)), 64'(0));

    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 11);
      op  = (sel <= 6) ? 4'(sel) : (sel == 7) ? 4'd4 : (sel == 8) ? 4'd5 :
            (sel == 9) ? 4'd3 : 4'($urandom_range(7, 15));
      plan_instr({op, 12'($urandom)}, $urandom_range(0, 2), $urandom_range(0, MEM_TIMEOUT),
                 $urandom_range(0, 3));
      play();
    end

    // async reset in the EXECUTE cycle of a MUL
    add_cycle(RDY, 1'b1, 16'h3456, 1'b0, 1'b0);
    ir_m = 16'h3456;
    add_cycle(PC, 1'b0, 16'h0000, 1'b0, 1'b0);
    play();
    @(posedge Clk); #2;
    pin("mul_execute_alu_mul", 64'(Alu_Mul), 64'(1));
    Rst_n = 1'b0;
    #1;
    pin("async_reset_outputs_zero", 64'(act_vec()), 64'(0));
    Instr_Valid = 1'b0; Resume = 1'b0; Mem_Ack = 1'b0;
    wen_seen = 0;
    repeat (2) begin @(negedge Clk); wen_seen += int'(Reg_Wr_En); end
    Rst_n = 1'b1;
    ir_m = 16'h0; cnt_m = '0; err_m = 1'b0;
    repeat (3) begin @(negedge Clk); #1; wen_seen += int'(Reg_Wr_En); end
    pin("no_write_after_reset", 64'(wen_seen), 64'(0));
    pin("retired_after_reset", 64'(Retired_Count), 64'(0));
    pin("ready_after_mid_reset", 64'(Instr_Ready), 64'(1));

    for (int k = 0; k < 20; k++) begin
      plan_instr({4'($urandom_range(0, 8)), 12'($urandom)}, $urandom_range(0, 1),
                 $urandom_range(0, MEM_TIMEOUT), $urandom_range(0, 2));
      play();
    end

    @(negedge Clk); #1;
    pin("exp_queue_drained", 64'(exp_q.size()), 64'(0));
    repeat (2) @(negedge Clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
